serial_frame_receiver: RTL

//   Receive-side deframer for the serial link driven by the Sender's bit-pattern

---
 rtl/serial_frame_receiver.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver
//   Receive-side deframer for a CE-strobed serial line. Each CE strobe samples
//   the line once: a low sample in IDLE is taken as the start bit. DATA_BITS
//   data bits follow, LSB first, and then one stop bit. A good frame is
//   presented on q_o with a valid_o/ack_i handshake. A stop bit sampled low
//   gives a one-cycle ferr_o pulse. The receiver then waits in BREAK until the
//   line has been sampled high again.
//
//   state | meaning
//   IDLE  | waiting for a low sample (start bit)
//   DATA  | shifting in data bits, LSB first
//   STOP  | next strobe samples the stop bit
//   BREAK | stop bit was low; waiting for the line to return high
//
// Ports
//   c_i      clock, all state changes on posedge
//   clr_i    synchronous active-high reset; overrides every other input
//   ce_i     bit strobe, one cycle per serial bit period
//   d_i      serial line, idle level 1
//   ack_i    consumer accepts q_o and clears valid_o
//   q_o      last good received word
//   valid_o  q_o holds an unread word
//   ferr_o   one-cycle pulse when the stop bit is sampled low
//   ovr_o    sticky: a good frame was dropped because valid_o was set and
//            ack_i was low
//   busy_o   high whenever the FSM is not in IDLE
module serial_frame_receiver #(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 c_i,
  input  logic                 clr_i,
  input  logic                 ce_i,
  input  logic                 d_i,
  input  logic                 ack_i,
  output logic [DATA_BITS-1:0] q_o,
  output logic                 valid_o,
  output logic                 ferr_o,
  output logic                 ovr_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    STOP  = 2'd2,
    BREAK = 2'd3
  } state_t;

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [DATA_BITS-1:0] q_q, q_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 good_frame;

  always_ff @(posedge c_i) begin
    if (clr_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    q_d        = q_q;
    valid_d    = valid_q;
    ferr_d     = 1'b0;
    ovr_d      = ovr_q;
    good_frame = 1'b0;

    case (state_q)
      IDLE: begin
        if (ce_i && !d_i) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        if (ce_i) begin
          // The new bit enters at the MSB. After DATA_BITS strobes, the
          // first bit received has been shifted down to the LSB.
          shift_d = (shift_q >> 1) | (DATA_BITS'(d_i) << (DATA_BITS - 1));
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == LAST_BIT) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (ce_i) begin
          if (d_i) begin
            good_frame = 1'b1;
            state_d    = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        // A line held low must not be taken as a new start bit.
        if (ce_i && d_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // At the completion edge, ack_i means the old word was consumed, so the
    // new word can replace it and valid_o stays set.
    if (good_frame) begin
      if (!valid_q) begin
        q_d     = shift_q;
        valid_d = 1'b1;
      end else if (ack_i) begin
        q_d = shift_q;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (ack_i) begin
      valid_d = 1'b0;
    end
  end

  assign q_o     = q_q;
  assign valid_o = valid_q;
  assign ferr_o  = ferr_q;
  assign ovr_o   = ovr_q;
  assign busy_o  = (state_q != IDLE);

endmodule
